rr_bus_interconnect: RTL and testbench
======================================

// Module: rr_bus_interconnect
// PURPOSE
//  Shared-bus interconnect, parametrised successor to the fixed 2-master/4-slave CPU/GPU bus.
//  Round-robin arbitration over NUM_MASTERS; parameter-driven base/mask address map over NUM_SLAVES.
//  Decode-miss and (optional) slave-timeout error responses. One transaction in flight.
//  Sits between CPU/GPU/DMA masters and memory/peripheral/config slaves.
// PARAMETERS
//  ADDR_WIDTH     64                  address width
//  DATA_WIDTH     64                  data width; BE_WIDTH = DATA_WIDTH/8 (localparam)
//  NUM_MASTERS    4                   requesters, >=2
//  NUM_SLAVES     4                   targets, >=1
//  SLAVE_BASE     pkg default map     [NUM_SLAVES][ADDR_WIDTH] region base per slave
//  SLAVE_MASK     pkg default map     [NUM_SLAVES][ADDR_WIDTH] compare mask per slave
//  TIMEOUT_CYCLES 256                 slave wait limit (used only with timeout feature)
// PORTS
//  clk        in   1                    clock
//  rst        in   1                    async reset, active-high
//  m_req      in   NUM_MASTERS          request, held until m_ready
//  m_addr     in   NUM_MASTERS*ADDR     address, stable while m_req
//  m_wdata    in   NUM_MASTERS*DATA     write data
//  m_we       in   NUM_MASTERS          1 = write
//  m_be       in   NUM_MASTERS*BE       byte enables
//  m_rdata    out  NUM_MASTERS*DATA     read data, valid with m_ready
//  m_ready    out  NUM_MASTERS          1-cycle completion pulse
//  m_err      out  NUM_MASTERS          error flag, valid with m_ready
//  s_req      out  NUM_SLAVES           one-hot request, held until s_ready
//  s_addr/s_wdata/s_we/s_be out per-slave   registered fields, zero when that s_req=0
//  s_rdata    in   NUM_SLAVES*DATA      slave read data, sampled on s_ready
//  s_ready    in   NUM_SLAVES           slave completion
//  busy       out  1                    FSM not IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0 (master 0 highest priority), all outputs 0.
//  Reset mid-transaction: abort; s_req drops asynchronously; no response to owner.
//  FSM: IDLE -> ISSUE | ERR; ISSUE -> RESP | ERR; RESP -> IDLE; ERR -> IDLE.
//  IDLE: any m_req -> grant first requester at/after pointer (wrap N-1 -> 0); latch
//   addr/wdata/we/be/owner; pointer <= owner+1 mod N. Decode hit -> ISSUE, miss -> ERR.
//  Decode: hit[j] = (addr & SLAVE_MASK[j]) == SLAVE_BASE[j]; lowest j wins on overlap.
//   No hit = decode error (no default slave).
//  ISSUE: s_req[sel]=1 with latched fields, held until s_ready[sel]; capture s_rdata -> RESP.
//   s_ready of unselected slaves ignored.
//  RESP: m_ready[owner]=1, m_rdata[owner]=captured data, m_err=0, exactly one cycle.
//  ERR: m_ready[owner]=1, m_err[owner]=1, m_rdata=0, one cycle; writes have no side effect.
//  Non-owner m_rdata/m_ready/m_err = 0 always.
//  Latency: req seen cycle 0 -> s_req cycle 1; s_ready in cycle k -> m_ready cycle k+1 (min 2).
//  Master rule: cycle after m_ready, m_req is either low or a new transaction.
//  Writes: m_rdata undefined-as-captured; masters ignore it.
//  Fairness: with all N requesting continuously, each granted once per N transactions.
// CONFIGURATION
//  INTERCONNECT_TIMEOUT_EN defined: ISSUE counter from 0; if s_ready not seen by count
//   TIMEOUT_CYCLES-1, drop s_req and go ERR (m_err=1). Late s_ready afterwards ignored.
//  Undefined: no counter; ISSUE waits indefinitely.
// STRUCTURE
//  interconnect_pkg: ic_state_e {IDLE,ISSUE,RESP,ERR}; default base/mask map
//   (main 0x0/2G, gpu 0x8000_0000/1G, periph 0xC000_0000/256M, cfg 0xF000_0000/256M).
//  Sub-module rr_arbiter #(N): req vector + pointer in, one-hot grant + index out,
//   pointer update on grant enable.
// TESTING
//  Reset -> all outputs 0, busy=0; m0 read 0x1000, slave0 ready cycle 1 -> m_ready[0] cycle 2.
//  m0..m3 all requesting continuously -> grant order 0,1,2,3,0; no master starved.
//  m1 write 0xC000_0010, be=0x0F -> only s_req[2], s_be[2]=0x0F; m_err[1]=0.
//  m2 read 0x1_0000_0000 (unmapped) -> no s_req, m_ready[2]=m_err[2]=1, m_rdata=0, cycle 1.
//  TIMEOUT_EN, TIMEOUT_CYCLES=8, slave1 silent -> s_req[1] 8 cycles then error; off: stalls.
//  rst asserted during ISSUE -> s_req 0 same cycle, IDLE, next req served by master 0 first.

Source files
------------

// File: rtl/interconnect_pkg.sv
// Shared types and the default four-region address map for rr_bus_interconnect.
package interconnect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        ERR   = 2'd3
    } ic_state_e;

    // Slave order: main memory (2G), gpu (1G), peripherals (256M), config (256M)
    localparam logic [3:0][63:0] IC_DEFAULT_BASE = {
        64'h0000_0000_F000_0000,
        64'h0000_0000_C000_0000,
        64'h0000_0000_8000_0000,
        64'h0000_0000_0000_0000
    };

    localparam logic [3:0][63:0] IC_DEFAULT_MASK = {
        64'hFFFF_FFFF_F000_0000,
        64'hFFFF_FFFF_F000_0000,
        64'hFFFF_FFFF_C000_0000,
        64'hFFFF_FFFF_8000_0000
    };

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// advances the pointer past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand_s;

    // Rotating priority search starting at the pointer
    always_comb begin
        gnt    = '0;
        idx    = '0;
        cand_s = '0;
        for (int i = 0; i < N; i++) begin
            cand_s = IW'((int'(ptr_q) + i) % N);
            if (req[cand_s] && (gnt == '0)) begin
                gnt[cand_s] = 1'b1;
                idx         = cand_s;
            end else begin
                idx = idx;
            end
        end
        any = |req;
    end

    // Pointer moves to winner+1 (wrapping) only when the grant is consumed
    always_comb begin
        if (en && any) begin
            ptr_d = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rr_bus_interconnect.sv
// Single-outstanding shared bus: round-robin master arbitration, base/mask slave decode,
// decode-miss errors. Define INTERCONNECT_TIMEOUT_EN to add the slave wait timeout.
module rr_bus_interconnect
    import interconnect_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_MASTERS    = 4,
    parameter int NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE = IC_DEFAULT_BASE,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_MASK = IC_DEFAULT_MASK,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_MASTERS-1:0]                    m_req,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]         m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]         m_wdata,
    input  logic [NUM_MASTERS-1:0]                    m_we,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]     m_be,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]         m_rdata,
    output logic [NUM_MASTERS-1:0]                    m_ready,
    output logic [NUM_MASTERS-1:0]                    m_err,
    output logic [NUM_SLAVES-1:0]                     s_req,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]          s_addr,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0]          s_wdata,
    output logic [NUM_SLAVES-1:0]                     s_we,
    output logic [NUM_SLAVES*(DATA_WIDTH/8)-1:0]      s_be,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]          s_rdata,
    input  logic [NUM_SLAVES-1:0]                     s_ready,
    output logic                                      busy
);
    localparam int AW  = ADDR_WIDTH;
    localparam int DW  = DATA_WIDTH;
    localparam int BW  = DATA_WIDTH / 8;
    localparam int MIW = $clog2(NUM_MASTERS);
    localparam int SIW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    if ((NUM_MASTERS < 2) || (NUM_SLAVES < 1) || (TIMEOUT_CYCLES < 2)) begin : g_cfg_check
        $error("rr_bus_interconnect: unsupported parameter set");
    end

    ic_state_e                  state_q, state_d;
    logic [MIW-1:0]             owner_q, owner_d;
    logic [SIW-1:0]             sel_q, sel_d;
    logic [NUM_MASTERS*DW-1:0]  m_rdata_q, m_rdata_d;
    logic [NUM_MASTERS-1:0]     m_ready_q, m_ready_d;
    logic [NUM_MASTERS-1:0]     m_err_q, m_err_d;
    logic [NUM_SLAVES-1:0]      s_req_q, s_req_d;
    logic [NUM_SLAVES*AW-1:0]   s_addr_q, s_addr_d;
    logic [NUM_SLAVES*DW-1:0]   s_wdata_q, s_wdata_d;
    logic [NUM_SLAVES-1:0]      s_we_q, s_we_d;
    logic [NUM_SLAVES*BW-1:0]   s_be_q, s_be_d;
    logic                       busy_q, busy_d;

    logic [NUM_MASTERS-1:0]     gnt_s;
    logic [MIW-1:0]             gidx_s;
    logic                       any_s;
    logic                       arb_en_s;
    logic [AW-1:0]              g_addr_s;
    logic [DW-1:0]              g_wdata_s;
    logic                       g_we_s;
    logic [BW-1:0]              g_be_s;
    logic                       dec_hit_s;
    logic [SIW-1:0]             dec_sel_s;
    logic [NUM_MASTERS-1:0]     owner_oh_s;
    logic [NUM_SLAVES-1:0]      sel_oh_s;
    logic [DW-1:0]              sel_rdata_s;
    logic                       sel_rdy_s;
    logic                       timeout_s;

    assign arb_en_s = (state_q == IDLE);

    rr_arbiter #(.N(NUM_MASTERS)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (m_req),
        .en  (arb_en_s),
        .gnt (gnt_s),
        .idx (gidx_s),
        .any (any_s)
    );

    // Route the granted master's request fields
    always_comb begin
        g_addr_s  = '0;
        g_wdata_s = '0;
        g_we_s    = 1'b0;
        g_be_s    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            g_addr_s  = g_addr_s  | (m_addr[i*AW +: AW]  & {AW{gnt_s[i]}});
            g_wdata_s = g_wdata_s | (m_wdata[i*DW +: DW] & {DW{gnt_s[i]}});
            g_we_s    = g_we_s    | (m_we[i] & gnt_s[i]);
            g_be_s    = g_be_s    | (m_be[i*BW +: BW]    & {BW{gnt_s[i]}});
        end
    end

    // Address decode; descending scan so the lowest matching slave wins overlaps
    always_comb begin
        dec_hit_s = 1'b0;
        dec_sel_s = '0;
        for (int j = NUM_SLAVES - 1; j >= 0; j--) begin
            if ((g_addr_s & SLAVE_MASK[j]) == SLAVE_BASE[j]) begin
                dec_hit_s = 1'b1;
                dec_sel_s = SIW'(j);
            end else begin
                dec_hit_s = dec_hit_s;
            end
        end
    end

    // One-hot views of the latched owner and target, plus the target's response
    always_comb begin
        owner_oh_s  = '0;
        sel_oh_s    = '0;
        sel_rdata_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            owner_oh_s[i] = (owner_q == MIW'(i));
        end
        for (int j = 0; j < NUM_SLAVES; j++) begin
            sel_oh_s[j] = (sel_q == SIW'(j));
            sel_rdata_s = sel_rdata_s | (s_rdata[j*DW +: DW] & {DW{sel_oh_s[j]}});
        end
        sel_rdy_s = |(s_ready & sel_oh_s);
    end

`ifdef INTERCONNECT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;

    // Wait counter runs only while a slave request is outstanding
    always_comb begin
        if (state_q == ISSUE) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Wait counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_s = (state_q == ISSUE) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Transaction FSM; slave fields stay zero unless a request is being presented
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        sel_d     = sel_q;
        m_rdata_d = '0;
        m_ready_d = '0;
        m_err_d   = '0;
        s_req_d   = '0;
        s_addr_d  = '0;
        s_wdata_d = '0;
        s_we_d    = '0;
        s_be_d    = '0;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    owner_d = gidx_s;
                    if (dec_hit_s) begin
                        state_d = ISSUE;
                        sel_d   = dec_sel_s;
                        for (int j = 0; j < NUM_SLAVES; j++) begin
                            s_req_d[j]             = (dec_sel_s == SIW'(j));
                            s_addr_d[j*AW +: AW]   = g_addr_s  & {AW{s_req_d[j]}};
                            s_wdata_d[j*DW +: DW]  = g_wdata_s & {DW{s_req_d[j]}};
                            s_we_d[j]              = g_we_s & s_req_d[j];
                            s_be_d[j*BW +: BW]     = g_be_s & {BW{s_req_d[j]}};
                        end
                    end else begin
                        state_d   = ERR;
                        m_ready_d = gnt_s;
                        m_err_d   = gnt_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (sel_rdy_s) begin
                    state_d   = RESP;
                    m_ready_d = owner_oh_s;
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        m_rdata_d[i*DW +: DW] = sel_rdata_s & {DW{owner_oh_s[i]}};
                    end
                end else if (timeout_s) begin
                    state_d   = ERR;
                    m_ready_d = owner_oh_s;
                    m_err_d   = owner_oh_s;
                end else begin
                    s_req_d   = s_req_q;
                    s_addr_d  = s_addr_q;
                    s_wdata_d = s_wdata_q;
                    s_we_d    = s_we_q;
                    s_be_d    = s_be_q;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any transaction silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            sel_q     <= '0;
            m_rdata_q <= '0;
            m_ready_q <= '0;
            m_err_q   <= '0;
            s_req_q   <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_we_q    <= '0;
            s_be_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            sel_q     <= sel_d;
            m_rdata_q <= m_rdata_d;
            m_ready_q <= m_ready_d;
            m_err_q   <= m_err_d;
            s_req_q   <= s_req_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_we_q    <= s_we_d;
            s_be_q    <= s_be_d;
            busy_q    <= busy_d;
        end
    end

    assign m_rdata = m_rdata_q;
    assign m_ready = m_ready_q;
    assign m_err   = m_err_q;
    assign s_req   = s_req_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_we    = s_we_q;
    assign s_be    = s_be_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_rr_bus_interconnect.sv
// Directed bench for rr_bus_interconnect: vector table plus reset, fairness and stall/timeout sequences.
module tb_rr_bus_interconnect;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   m_req;
    logic [255:0] m_addr, m_wdata;
    logic [3:0]   m_we;
    logic [31:0]  m_be;
    logic [255:0] m_rdata;
    logic [3:0]   m_ready, m_err;
    logic [3:0]   s_req;
    logic [255:0] s_addr, s_wdata;
    logic [3:0]   s_we;
    logic [31:0]  s_be;
    logic [255:0] s_rdata;
    logic [3:0]   s_ready;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    rr_bus_interconnect #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_be(m_be),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
        .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_be(s_be),
        .s_rdata(s_rdata), .s_ready(s_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  be;
        int          dly;
        logic        hit;
        int          sl;
        logic [63:0] rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_masters();
        m_req = '0; m_addr = '0; m_wdata = '0; m_we = '0; m_be = '0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0]   e_sreq;
        logic [3:0]   e_mrdy;
        logic [255:0] e_rdata;
        int           other;
        e_sreq  = 4'b0001 << v.sl;
        e_mrdy  = 4'b0001 << v.m;
        e_rdata = 256'(v.rdata) << (v.m * 64);
        other   = (v.sl + 1) % 4;
        @(negedge clk);
        m_req[v.m] = 1'b1;
        m_addr[v.m*64 +: 64]  = v.addr;
        m_wdata[v.m*64 +: 64] = v.wdata;
        m_we[v.m]             = v.we;
        m_be[v.m*8 +: 8]      = v.be;
        @(negedge clk);
        if (v.hit) begin
            chk("issue_s_req", 256'(s_req), 256'(e_sreq));
            chk("issue_s_addr", 256'(s_addr[v.sl*64 +: 64]), 256'(v.addr));
            chk("issue_s_wdata", 256'(s_wdata[v.sl*64 +: 64]), 256'(v.wdata));
            chk("issue_s_we_be", 256'({s_we[v.sl], s_be[v.sl*8 +: 8]}), 256'({v.we, v.be}));
            chk("issue_no_ready", 256'(m_ready), 256'(0));
            for (int d = 0; d < v.dly; d++) begin
                s_ready[other] = 1'b1;
                s_rdata[other*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
                @(negedge clk);
                s_ready = '0;
                chk("hold_s_req", 256'({s_req, m_ready}), 256'({e_sreq, 4'b0000}));
            end
            s_ready[v.sl] = 1'b1;
            s_rdata[v.sl*64 +: 64] = v.rdata;
            @(negedge clk);
            s_ready = '0;
            chk("resp_m_ready", 256'(m_ready), 256'(e_mrdy));
            chk("resp_m_err", 256'(m_err), 256'(0));
            chk("resp_s_req_drop", 256'(s_req), 256'(0));
            if (!v.we) begin
                chk("resp_m_rdata", m_rdata, e_rdata);
            end
        end else begin
            chk("miss_s_req", 256'(s_req), 256'(0));
            chk("miss_m_ready", 256'(m_ready), 256'(e_mrdy));
            chk("miss_m_err", 256'(m_err), 256'(e_mrdy));
            chk("miss_m_rdata", m_rdata, 256'(0));
        end
        clear_masters();
        @(negedge clk);
        chk("post_idle", 256'({m_ready, m_err, busy}), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 64'h0000_0000_0000_1000, 1'b0, 64'h0, 8'hFF, 0, 1'b1, 0, 64'h1111_2222_3333_4444};
        vecs[1] = '{1, 64'h0000_0000_C000_0010, 1'b1, 64'h0000_0000_DEAD_BEEF, 8'h0F, 2, 1'b1, 2, 64'h0};
        vecs[2] = '{2, 64'h0000_0001_0000_0000, 1'b0, 64'h0, 8'hFF, 0, 1'b0, 0, 64'h0};
        vecs[3] = '{3, 64'h0000_0000_8000_0040, 1'b0, 64'h0, 8'hFF, 1, 1'b1, 1, 64'hA5A5_5A5A_0F0F_F0F0};
        vecs[4] = '{0, 64'h0000_0000_F000_0008, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 1'b1, 3, 64'h0};
        vecs[5] = '{1, 64'h0000_0000_7FFF_FFF8, 1'b0, 64'h0, 8'hF0, 3, 1'b1, 0, 64'hCAFE_F00D_1234_5678};
        vecs[6] = '{2, 64'h0000_0000_D000_0000, 1'b0, 64'h0, 8'hFF, 0, 1'b0, 0, 64'h0};
        vecs[7] = '{3, 64'h0000_0000_BFFF_FFFF, 1'b0, 64'h0, 8'h01, 0, 1'b1, 1, 64'hFEED_FACE_0BAD_BEEF};

        rst = 1'b1;
        clear_masters();
        s_rdata = '0;
        s_ready = '0;
        repeat (3) @(negedge clk);
        chk("reset_m_out", {m_rdata[251:0], m_ready}, 256'(0));
        chk("reset_s_req", 256'({s_req, s_we, s_be, busy, m_err}), 256'(0));
        chk("reset_s_addr", s_addr | s_wdata, 256'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Slave 1 never answers
        @(negedge clk);
        m_req[3] = 1'b1;
        m_addr[3*64 +: 64] = 64'h0000_0000_8000_0100;
`ifdef INTERCONNECT_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("to_wait", 256'({s_req, m_ready, busy}), 256'({4'b0010, 4'b0000, 1'b1}));
        end
        @(negedge clk);
        chk("to_err", 256'({s_req, m_ready, m_err}), 256'({4'b0000, 4'b1000, 4'b1000}));
        chk("to_rdata", m_rdata, 256'(0));
        clear_masters();
        s_ready[1] = 1'b1;
        @(negedge clk);
        s_ready = '0;
        @(negedge clk);
        chk("to_late_ready", 256'({m_ready, busy, s_req}), 256'(0));
`else
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("stall_wait", 256'({s_req, m_ready, busy}), 256'({4'b0010, 4'b0000, 1'b1}));
        end
        s_ready[1] = 1'b1;
        s_rdata[1*64 +: 64] = 64'h0000_0000_5151_1515;
        @(negedge clk);
        s_ready = '0;
        chk("stall_resp", 256'({m_ready, m_err}), 256'({4'b1000, 4'b0000}));
        chk("stall_rdata", m_rdata, 256'(64'h0000_0000_5151_1515) << 192);
        clear_masters();
        @(negedge clk);
`endif

        // Reset while a slave request is outstanding
        @(negedge clk);
        m_req[1] = 1'b1;
        m_addr[1*64 +: 64] = 64'h0000_0000_8000_0000;
        @(negedge clk);
        chk("rst_pre_issue", 256'(s_req), 256'({4'b0010}));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_drop", 256'({s_req, busy, m_ready}), 256'(0));
        clear_masters();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_no_response", 256'({m_ready, m_err, busy}), 256'(0));

        // All masters requesting continuously: grants rotate from master 0
        for (int i = 0; i < 4; i++) begin
            m_addr[i*64 +: 64] = 64'h0000_0000_0000_1000;
        end
        m_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            logic [3:0] e_g;
            int c;
            e_g = 4'b0001 << (t % 4);
            c = 0;
            while (!s_req[0] && (c < 20)) begin
                @(negedge clk);
                c++;
            end
            chk("fair_s_req", 256'(s_req), 256'(4'b0001));
            s_ready[0] = 1'b1;
            s_rdata[63:0] = 64'(t);
            @(negedge clk);
            s_ready = '0;
            chk("fair_grant", 256'(m_ready), 256'(e_g));
        end
        clear_masters();
        repeat (2) @(negedge clk);
        chk("fair_idle", 256'({busy, s_req}), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
